dma_bus: RTL

DMA_BUS -- requirements
Module: dma_bus

---
 rtl/dma_bus.sv | 87 ++++++++
 1 files changed

// File: rtl/dma_bus.sv
// Two-master, two-slave shared bus with a non-preemptive arbiter.
// Master 0 owns the bus by default; read data returns one cycle after select.
module dma_bus (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_address,
    input  logic [31:0] M0_dout,
    output logic        M0_grant,
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M1_dout,
    output logic        M1_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout
);

    typedef enum logic {
        GRANT_M0 = 1'b0,
        GRANT_M1 = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rsel_q, rsel_d;
    logic        g_req;
    logic        g_wr;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= GRANT_M0;
            rsel_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            rsel_q  <= rsel_d;
        end
    end

    // The owner keeps the bus for as long as it holds req.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GRANT_M0: if (!M0_req && M1_req) state_d = GRANT_M1;
            GRANT_M1: if (!M1_req)           state_d = GRANT_M0;
            default:                         state_d = GRANT_M0;
        endcase
    end

    assign M0_grant = (state_q == GRANT_M0);
    assign M1_grant = (state_q == GRANT_M1);

    always_comb begin
        g_req     = M0_req;
        g_wr      = M0_wr;
        S_address = M0_address;
        S_din     = M0_dout;
        if (state_q == GRANT_M1) begin
            g_req     = M1_req;
            g_wr      = M1_wr;
            S_address = M1_address;
            S_din     = M1_dout;
        end
    end

    // Unmapped addresses select nothing, so writes there vanish.
    assign S0_sel = g_req && (S_address[7:5] == 3'b000);
    assign S1_sel = g_req && (S_address[7:5] == 3'b001);
    assign S_wr   = g_wr && g_req;
    assign rsel_d = {S1_sel, S0_sel};

    always_comb begin
        M_din = 32'h0;
        case (rsel_q)
            2'b01:   M_din = S0_dout;
            2'b10:   M_din = S1_dout;
            default: M_din = 32'h0;
        endcase
    end

endmodule
